// File: rtl/presubaddor_inverse_unsigned_10_bit_pkg.sv
// Shared widths and FSM encoding for the inverse pre-sub/add block.
// Recovers d from p = ((d - a) * b) + c.
package presubaddor_pkg;
   localparam int OP_W   = 10;
   localparam int RES_W  = 20;
   localparam int N_ITER = 20;
   localparam int CNT_W  = 5;

   typedef enum logic [2:0] {
      IDLE,
      SUB,
      DIV,
      ADD,
      DONE
   } state_t;
endpackage

// File: rtl/presubaddor_inverse_unsigned_10_bit_div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract,
// emit the quotient bit and the restored or reduced remainder.
module presubaddor_div_step
   import presubaddor_pkg::*;
(
   input  logic [OP_W-1:0] rem_in,
   input  logic            bit_in,
   input  logic [OP_W-1:0] divisor,
   output logic [OP_W-1:0] rem_out,
   output logic            q_bit
);

   logic [OP_W:0] shifted;
   logic [OP_W:0] trial;

   // rem_in < divisor, so shifted < 2*divisor and a borrow shows in the MSB
   always_comb begin
      shifted = {rem_in, bit_in};
      trial   = shifted - {1'b0, divisor};
      q_bit   = ~trial[OP_W];
      rem_out = q_bit ? trial[OP_W-1:0] : shifted[OP_W-1:0];
   end

endmodule

// File: rtl/presubaddor_inverse_unsigned_10_bit.sv
// Multi-cycle inverse of ((d - a) * b) + c: subtract, divide, add back.
// Valid/ready on both sides; one request in flight.
module presubaddor_inverse_unsigned_10_bit
   import presubaddor_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RES_W-1:0] p,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   input  logic [OP_W-1:0]  c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OP_W-1:0]  d,
   output logic [OP_W-1:0]  rem,
   output logic             err
);

   state_t           state;
   logic [RES_W-1:0] p_r;
   logic [OP_W-1:0]  a_r;
   logic [OP_W-1:0]  b_r;
   logic [OP_W-1:0]  c_r;
   logic [RES_W-1:0] quo;
   logic [OP_W-1:0]  part;
   logic [CNT_W-1:0] cnt;

   logic [RES_W-1:0] c_ext;
   logic [OP_W-1:0]  part_next;
   logic             q_bit;
   logic [OP_W:0]    sum;

   assign c_ext = {{(RES_W-OP_W){1'b0}}, c_r};
   assign sum   = {1'b0, quo[OP_W-1:0]} + {1'b0, a_r};

   // quo starts as the dividend and shifts quotient bits in from the LSB
   presubaddor_div_step u_step (
      .rem_in  (part),
      .bit_in  (quo[RES_W-1]),
      .divisor (b_r),
      .rem_out (part_next),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         d         <= '0;
         rem       <= '0;
         err       <= 1'b0;
         p_r       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         c_r       <= '0;
         quo       <= '0;
         part      <= '0;
         cnt       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  p_r      <= p;
                  a_r      <= a;
                  b_r      <= b;
                  c_r      <= c;
                  in_ready <= 1'b0;
                  state    <= SUB;
               end
            end
            SUB: begin
               if (b_r == '0 || p_r < c_ext) begin
                  d         <= '0;
                  rem       <= '0;
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  quo   <= p_r - c_ext;
                  part  <= '0;
                  cnt   <= '0;
                  state <= DIV;
               end
            end
            DIV: begin
               quo  <= {quo[RES_W-2:0], q_bit};
               part <= part_next;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(N_ITER - 1))
                  state <= ADD;
            end
            ADD: begin
               d         <= sum[OP_W-1:0];
               rem       <= part;
               err       <= (|quo[RES_W-1:OP_W]) | sum[OP_W];
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_presubaddor_inverse_unsigned_10_bit.sv
// Scoreboard bench: driver pushes model results, monitor pops on out_valid.
// Random and directed requests, stalls and a mid-divide reset.
module tb_presubaddor_inverse_unsigned_10_bit;

   typedef struct {
      int d;
      int rem;
      int err;
      int lat;
      int acc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] p;
   logic [9:0]  a;
   logic [9:0]  b;
   logic [9:0]  c;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  d;
   logic [9:0]  rem;
   logic        err;

   int   nchk;
   int   nerr;
   int   cyc;
   bit   auto_or;
   bit   prev_ov;
   bit   have_cur;
   exp_t cur;
   exp_t sb[$];

   presubaddor_inverse_unsigned_10_bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .p         (p),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .rem       (rem),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(string name, int act, int expv);
      nchk++;
      if (act != expv) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Reference model from the arithmetic definition
   function automatic exp_t model(int av, int bv, int cv, int pv);
      exp_t e;
      int   q;
      e.acc = 0;
      if (bv == 0 || pv < cv) begin
         e.d = 0; e.rem = 0; e.err = 1; e.lat = 1;
      end else begin
         q     = (pv - cv) / bv;
         e.rem = (pv - cv) % bv;
         e.d   = (q + av) % 1024;
         e.err = (q > 1023 || (q % 1024) + av > 1023) ? 1 : 0;
         e.lat = 22;
      end
      return e;
   endfunction

   task automatic send(int av, int bv, int cv, int pv);
      exp_t e;
      int   t;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 0, 1);
         return;
      end
      a = 10'(av); b = 10'(bv); c = 10'(cv); p = 20'(pv);
      in_valid = 1'b1;
      e = model(av, bv, cv, pv);
      e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      // scrambled operands while busy must not matter
      a = 10'($urandom); b = 10'($urandom);
      c = 10'($urandom); p = 20'($urandom);
   endtask

   task automatic send_rand();
      int av, bv, cv, pv, q, r;
      av = $urandom_range(0, 1023);
      cv = $urandom_range(0, 1023);
      bv = ($urandom % 10 == 0) ? 0 : $urandom_range(1, 1023);
      if ($urandom % 4 == 0 || bv == 0) begin
         pv = $urandom_range(0, 20'hFFFFF);
      end else begin
         q  = $urandom_range(0, 1100);
         r  = $urandom_range(0, bv - 1);
         pv = (q * bv + cv + r) & 20'hFFFFF;
      end
      send(av, bv, cv, pv);
   endtask

   always @(negedge clk) begin
      if (auto_or) out_ready = ($urandom % 4) != 0;
   end

   always @(negedge clk) begin
      if (out_valid) begin
         if (!prev_ov) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
               have_cur = 1'b0;
            end else begin
               cur = sb.pop_front();
               have_cur = 1'b1;
               chk("latency", cyc - cur.acc, cur.lat);
            end
         end
         if (have_cur) begin
            chk("d", int'(d), cur.d);
            chk("rem", int'(rem), cur.rem);
            chk("err", int'(err), cur.err);
            chk("in_ready_busy", int'(in_ready), 0);
         end
      end
      prev_ov = out_valid;
   end

   initial begin
      int t;
      nchk = 0; nerr = 0; cyc = 0;
      prev_ov = 1'b0; have_cur = 1'b0;
      auto_or = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; c = '0; p = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_d", int'(d), 0);
      chk("rst_rem", int'(rem), 0);
      chk("rst_err", int'(err), 0);
      rst_n = 1'b1;
      @(negedge clk);

      send(200, 37, 15, 18515);
      send(200, 37, 15, 18520);
      send(123, 0, 9, 500);
      send(7, 3, 15, 10);
      send(1000, 1, 0, 100);
      send(0, 1023, 0, 1023 * 1023 + 1022);
      send(5, 1, 0, 0);

      auto_or = 1'b1;
      repeat (60) send_rand();

      // stall the consumer for 10 cycles on a normal result
      t = 0;
      while ((sb.size() != 0 || out_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      auto_or = 1'b0;
      #1 out_ready = 1'b0;
      send(200, 37, 15, 18520);
      t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("stall_out_valid", int'(out_valid), 1);
      repeat (10) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_hs_in_ready", int'(in_ready), 1);
      chk("post_hs_out_valid", int'(out_valid), 0);

      // reset during divide iteration 7
      send(200, 37, 15, 18515);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", int'(in_ready), 1);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_d", int'(d), 0);
      chk("abort_rem", int'(rem), 0);
      chk("abort_err", int'(err), 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(0, 1, 0, 5);

      t = 0;
      while ((sb.size() != 0 || out_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", sb.size(), 0);
      chk("drain_out_valid", int'(out_valid), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
